// File: rtl/vga_plot_buffer.sv
// vga_plot_buffer: elastic pixel-write FIFO between drawing engines and the
// VGA adapter write port. Off-screen requests are clipped (consumed, not
// stored); the head entry is presented on registered out_* outputs.
// Optional feature macro: PLOT_DEDUP_EN -- drop a push identical to the most
// recently stored entry.
module vga_plot_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_x,
    input  logic [6:0]    in_y,
    input  logic [2:0]    in_colour,
    input  logic          in_plot,
    output logic          in_ready,
    output logic [7:0]    out_x,
    output logic [6:0]    out_y,
    output logic [2:0]    out_colour,
    output logic          out_plot,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [17:0]   r_head;
    logic          r_overflow;

    logic [17:0]   w_in;
    logic          w_push;
    logic          w_clip;
    logic          w_dup;
    logic          w_store;
    logic          w_pop;
    logic [AW-1:0] w_rptr_inc;

    assign w_in       = {in_x, in_y, in_colour};
    assign in_ready   = (r_count != C_FULL);
    assign out_plot   = (r_count != '0);
    assign w_push     = in_plot && in_ready;
    assign w_clip     = (in_x > 8'd159) || (in_y > 7'd119);
    assign w_store    = w_push && !w_clip && !w_dup;
    assign w_pop      = out_plot && out_ready;
    assign w_rptr_inc = r_rptr + AW'(1);

`ifdef PLOT_DEDUP_EN
    logic        r_last_vld;
    logic [17:0] r_last;

    assign w_dup = r_last_vld && (w_in == r_last);

    // Remember the most recently stored entry for duplicate suppression
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_vld <= 1'b0;
            r_last     <= '0;
        end else if (w_store) begin
            r_last_vld <= 1'b1;
            r_last     <= w_in;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wptr] <= w_in;
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) r_wptr <= r_wptr + AW'(1);
            if (w_pop)   r_rptr <= w_rptr_inc;
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head register: tracks the entry that will be at the head after this
    // edge, bypassing the array when the incoming push becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_pop) begin
            if (r_count >= (AW+1)'(2)) r_head <= r_mem[w_rptr_inc];
            else if (w_store)          r_head <= w_in;
        end else if (r_count == '0 && w_store) begin
            r_head <= w_in;
        end
    end

    // Sticky overflow: request seen while the buffer was full
    always_ff @(posedge clk) begin
        if (rst)                      r_overflow <= 1'b0;
        else if (in_plot && !in_ready) r_overflow <= 1'b1;
    end

    assign out_x      = r_head[17:10];
    assign out_y      = r_head[9:3];
    assign out_colour = r_head[2:0];
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_vga_plot_buffer.sv
// Bench for vga_plot_buffer: scoreboard queue of expected stored entries,
// filled when an accepted request is seen and drained when the adapter pops.
module tb_vga_plot_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_x;
    logic [6:0]    in_y;
    logic [2:0]    in_colour;
    logic          in_plot;
    logic          in_ready;
    logic [7:0]    out_x;
    logic [6:0]    out_y;
    logic [2:0]    out_colour;
    logic          out_plot;
    logic          out_ready;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [17:0] sb_q[$];
    logic        exp_ovf = 1'b0;
    logic        last_vld = 1'b0;
    logic [17:0] last_ent = '0;
    logic        mon_en = 1'b0;

    vga_plot_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_ready(in_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .out_plot(out_plot), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        in_plot   = p;
        in_x      = x;
        in_y      = y;
        in_colour = c;
    endtask

    // Per-cycle model: compare against the state before the coming edge,
    // then advance the model by what that edge will do.
    always @(negedge clk) begin
        logic [17:0] e, ent;
        logic        clip, store;
        if (mon_en) begin
            chk("count",    32'(count),    32'(sb_q.size()));
            chk("out_plot", 32'(out_plot), 32'(sb_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb_q.size() != DEPTH));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (rst) begin
                sb_q.delete();
                exp_ovf  = 1'b0;
                last_vld = 1'b0;
            end else begin
                if (out_plot && out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("head", 32'({out_x, out_y, out_colour}), 32'(e));
                end
                if (in_plot && !in_ready) exp_ovf = 1'b1;
                ent  = {in_x, in_y, in_colour};
                clip = (in_x > 8'd159) || (in_y > 7'd119);
                store = in_plot && in_ready && !clip;
`ifdef PLOT_DEDUP_EN
                if (last_vld && ent == last_ent) store = 1'b0;
`endif
                if (store) begin
                    sb_q.push_back(ent);
                    last_vld = 1'b1;
                    last_ent = ent;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        step();
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        // reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_plot",  32'(out_plot), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_out",   32'({out_x, out_y, out_colour}), 0);

        // 1: three pushes, adapter always ready
        out_ready = 1'b1;
        drive(1'b1, 8'd0, 7'd0, 3'd1); step();
        chk("t1_lat_plot", 32'(out_plot), 1);
        chk("t1_lat_head", 32'({out_x, out_y, out_colour}), 32'({8'd0, 7'd0, 3'd1}));
        drive(1'b1, 8'd1, 7'd0, 3'd2); step();
        drive(1'b1, 8'd2, 7'd0, 3'd3); step();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        repeat (3) step();
        chk("t1_empty", 32'(count), 0);

        // 2: fill, overflow, drain
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i * 9), 7'(i * 7), 3'(i));
            step();
        end
        chk("t2_full", 32'(count), DEPTH);
        chk("t2_ready", 32'(in_ready), 0);
        drive(1'b1, 8'd100, 7'd100, 3'd5); step();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_cnt", 32'(count), DEPTH);
        repeat (3) step();
        chk("t2_hold", 32'({out_x, out_y, out_colour}), 32'({8'd0, 7'd0, 3'd0}));
        out_ready = 1'b1;
        repeat (DEPTH) step();
        chk("t2_drained", 32'(count), 0);
        chk("t2_ovf_sticky", 32'(overflow), 1);

        // 3: clipped requests
        do_reset();
        drive(1'b1, 8'd160, 7'd5, 3'd7); step();
        drive(1'b1, 8'd10, 7'd120, 3'd7); step();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("t3_cnt", 32'(count), 0);
        chk("t3_plot", 32'(out_plot), 0);
        // boundary corner still stored
        drive(1'b1, 8'd159, 7'd119, 3'd6); step();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("t3_corner", 32'({out_x, out_y, out_colour}), 32'({8'd159, 7'd119, 3'd6}));
        step();

        // 4: steady state push+pop at count 8
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(20 + i), 7'(i), 3'(i + 1));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(50 + i), 7'(30 + i), 3'(i));
            step();
        end
        chk("t4_cnt", 32'(count), 8);
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        repeat (10) step();
        chk("t4_empty", 32'(count), 0);

        // 5: reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 7'(i), 3'(i));
            step();
        end
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("t5_cnt5", 32'(count), 5);
        do_reset();
        chk("t5_cnt", 32'(count), 0);
        chk("t5_plot", 32'(out_plot), 0);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_ready", 32'(in_ready), 1);

        // 6: duplicate suppression
        drive(1'b1, 8'd4, 7'd4, 3'd2); step();
        drive(1'b1, 8'd4, 7'd4, 3'd2); step();
        drive(1'b1, 8'd4, 7'd4, 3'd3); step();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
`ifdef PLOT_DEDUP_EN
        chk("t6_cnt", 32'(count), 2);
`else
        chk("t6_cnt", 32'(count), 3);
`endif
        out_ready = 1'b1;
        repeat (4) step();
        chk("t6_empty", 32'(count), 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
